// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and word geometry.
// Optional checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // A load request is legal when it asks for at least one word and fits the memory.
   function automatic logic len_in_range(input logic [31:0] len, input logic [31:0] depth);
      return (len != 32'd0) && (len <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: first byte lands in bits [7:0].
// Emits a one-cycle word-valid pulse the cycle after the final byte of a word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr,
   input  logic        i_fire,
   input  logic [7:0]  i_byte,
   output logic        o_last_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [BYTE_IDX_W-1:0] r_idx;
   logic [31:0]           r_shift;
   logic [31:0]           r_word;
   logic                  r_word_valid;
   logic [31:0]           w_shift_in;

   assign w_shift_in   = {i_byte, r_shift[31:8]};
   assign o_last_byte  = (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx        <= '0;
         r_shift      <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
         end else if (i_fire) begin
            r_shift <= w_shift_in;
            if (o_last_byte) begin
               // Separate holding register keeps wdata stable while the next word assembles.
               r_idx        <= '0;
               r_word       <= w_shift_in;
               r_word_valid <= 1'b1;
            end else begin
               r_idx <= r_idx + BYTE_IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t          r_state;
   state_t          w_state_next;
   logic [ADDR_W:0] r_len;
   logic [ADDR_W:0] r_wcnt;
   logic            r_fin;
   logic            r_err;
   logic            r_hold;
   logic            w_err_next;
   logic            w_hold_next;
   logic            w_start_acc;
   logic            w_len_ok;
   logic            w_load_fire;
   logic            w_last_byte;
   logic            w_last_word;
   logic            w_word_valid;
   logic [31:0]     w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]      r_xor;
   logic            w_ck_bad;
`endif

   assign w_len_ok    = len_in_range(32'(len_words), 32'(DEPTH_WORDS));
   assign w_load_fire = (r_state == ST_LOAD) && rx_valid && rx_ready;
   assign w_last_word = (r_wcnt == (r_len - (ADDR_W+1)'(1)));
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign w_ck_bad    = (rx_data != r_xor);
`endif

   byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_clr        (w_start_acc),
      .i_fire       (w_load_fire),
      .i_byte       (rx_data),
      .o_last_byte  (w_last_byte),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_comb begin
      w_state_next = r_state;
      w_err_next   = r_err;
      w_hold_next  = r_hold;
      w_start_acc  = 1'b0;
      rx_ready     = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_hold_next = 1'b1;
               if (w_len_ok) begin
                  w_state_next = ST_LOAD;
                  w_err_next   = 1'b0;
               end else begin
                  w_state_next = ST_DONE;
                  w_err_next   = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            // Input is throttled during the final write so no byte past the payload is taken.
            rx_ready = !r_fin;
            if (r_fin) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_state_next = ST_CHECK;
`else
               w_state_next = ST_DONE;
               w_hold_next  = 1'b0;
`endif
            end
         end
         ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            rx_ready = 1'b1;
            if (rx_valid) begin
               w_state_next = ST_DONE;
               w_err_next   = w_ck_bad;
               w_hold_next  = w_ck_bad;
            end
`else
            w_state_next = ST_IDLE;
`endif
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_wcnt  <= '0;
         r_fin   <= 1'b0;
         r_err   <= 1'b0;
         r_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor   <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         r_err   <= w_err_next;
         r_hold  <= w_hold_next;
         r_fin   <= w_load_fire && w_last_byte && w_last_word;
         if (w_start_acc) begin
            r_len  <= len_words;
            r_wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor  <= '0;
`endif
         end else begin
            if (w_word_valid)
               r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_load_fire)
               r_xor <= r_xor ^ rx_data;
`endif
         end
      end
   end

   assign we       = w_word_valid;
   assign waddr    = r_wcnt[ADDR_W-1:0];
   assign wdata    = w_word;
   assign cpu_hold = r_hold;
   assign busy     = (r_state == ST_LOAD) || (r_state == ST_CHECK);
   assign done     = (r_state == ST_DONE);
   assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader; expected words come from the byte stream itself.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len_words = '0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  tx_q[$];
   int          wq_addr[$];
   logic [31:0] wq_data[$];

   imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .len_words(len_words),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Memory write monitor: we is a full-cycle pulse, so the falling edge sees it.
   always @(negedge clk) begin
      if (reset && we) begin
         wq_addr.push_back(int'(waddr));
         wq_data.push_back(wdata);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},       32'(we),       32'd0);
      check({tag, "_waddr"},    32'(waddr),    32'd0);
      check({tag, "_wdata"},    wdata,         32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_err"},      32'(err),      32'd0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
   endtask

   task automatic pulse_start(input int len);
      start     = 1'b1;
      len_words = len[AW:0];
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Offer one byte and hold it until the loader takes it (bounded wait).
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int t;
      t        = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 64) begin
         @(negedge clk);
         t++;
      end
      ok = rx_ready;
      if (ok) @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (!done && t < 64) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done"}, 32'(done), 32'd1);
   endtask

   // One complete load of n words; bytes come from tx_q when preset, else random.
   task automatic run_load(input string tag, input int n, input bit preset,
                           input int gap_lo, input int gap_hi, input int start_at,
                           input bit corrupt_ck);
      logic [7:0]  ck;
      logic [31:0] exp_word;
      bit          ok;
      bit          exp_err;
      ck = 8'h00;
      exp_err = 1'b0;
      wq_addr.delete();
      wq_data.delete();
      if (!preset) begin
         tx_q.delete();
         for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
      end
      pulse_start(n);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      for (int i = 0; i < 4 * n; i++) begin
         if (i == start_at) pulse_start(3);
         send_byte(tx_q[i], ok);
         if (!ok) check({tag, "_rx_timeout"}, 32'd0, 32'd1);
         ck = ck ^ tx_q[i];
         repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = corrupt_ck;
      send_byte(corrupt_ck ? (ck ^ 8'hF0) : ck, ok);
      if (!ok) check({tag, "_ck_timeout"}, 32'd0, 32'd1);
`endif
      wait_done(tag);
      check({tag, "_err"},      32'(err),      32'(exp_err));
      check({tag, "_hold_end"}, 32'(cpu_hold), 32'(exp_err));
      check({tag, "_busy_end"}, 32'(busy),     32'd0);
      check({tag, "_rdy_end"},  32'(rx_ready), 32'd0);
      check({tag, "_nwrites"},  32'(wq_data.size()), 32'(n));
      for (int i = 0; i < n && i < wq_data.size(); i++) begin
         exp_word = {tx_q[4*i+3], tx_q[4*i+2], tx_q[4*i+1], tx_q[4*i]};
         check($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_word);
      end
      $display("load %s: %0d words, gaps %0d..%0d, err=%0d", tag, n, gap_lo, gap_hi, err);
   endtask

   task automatic bad_len(input string tag, input int len);
      wq_data.delete();
      wq_addr.delete();
      pulse_start(len);
      check({tag, "_done"}, 32'(done),     32'd1);
      check({tag, "_err"},  32'(err),      32'd1);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_busy"}, 32'(busy),     32'd0);
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      repeat (8) @(negedge clk);
      check({tag, "_rdy"}, 32'(rx_ready), 32'd0);
      rx_valid = 1'b0;
      check({tag, "_nowrite"}, 32'(wq_data.size()), 32'd0);
      $display("bad length %0d: done=%0d err=%0d hold=%0d", len, done, err, cpu_hold);
   endtask

   initial begin
      bit ok;
      // Reset values, while reset is held and just after release.
      @(negedge clk);
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("idle");
      $display("reset: outputs checked");

      // Worked example: two RISC-V instructions.
      tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load("ex2", 2, 1'b1, 0, 0, -1, 1'b0);
      check("ex2_w0", (wq_data.size() > 0) ? wq_data[0] : 32'hDEAD_BEEF, 32'h0000_0013);
      check("ex2_w1", (wq_data.size() > 1) ? wq_data[1] : 32'hDEAD_BEEF, 32'h0010_0093);

      // Illegal lengths, also exercising start from DONE.
      bad_len("len0", 0);
      bad_len("lenmax1", DEPTH + 1);

      // Alternating valid, one byte per two cycles.
      tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load("toggle", 1, 1'b1, 1, 1, -1, 1'b0);
      check("toggle_word", (wq_data.size() > 0) ? wq_data[0] : 32'hDEAD_BEEF, 32'hDDCC_BBAA);

      // Bytes offered while DONE must be ignored; the next load must stay aligned.
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;

      // Randomized loads with random gaps, one with a stray start mid-stream.
      for (int k = 0; k < 6; k++)
         run_load($sformatf("rnd%0d", k), $urandom_range(6, 1), 1'b0, 0, k % 3, -1, 1'b0);
      run_load("midstart", 4, 1'b0, 0, 1, 6, 1'b0);

      // Reset partway through a load.
      tx_q.delete();
      for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
      wq_data.delete();
      wq_addr.delete();
      pulse_start(2);
      for (int i = 0; i < 5; i++) send_byte(tx_q[i], ok);
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      check("midrst_nwrites", 32'(wq_data.size()), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      $display("reset mid-load: outputs checked");
      run_load("after_rst", 1, 1'b0, 0, 0, -1, 1'b0);

      // Full-depth load, back-to-back bytes.
      run_load("full", DEPTH, 1'b0, 0, 0, -1, 1'b0);
      check("full_lastaddr", (wq_addr.size() > 0) ? 32'(wq_addr[wq_addr.size()-1]) : 32'hFFFF_FFFF,
            32'(DEPTH - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
      tx_q = '{8'h01, 8'h02, 8'h04, 8'h08};
      run_load("ck_good", 1, 1'b1, 0, 0, -1, 1'b0);
      run_load("ck_bad", 1, 1'b1, 0, 0, -1, 1'b1);
      run_load("ck_rnd", 3, 1'b0, 0, 2, -1, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 10: word-address width; DEPTH_WORDS <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port len_words  input  ADDR_W+1  word count, sampled on accepted start.
REQ-007 SHALL have port rx_data  input  8  incoming program byte.
REQ-008 SHALL have port rx_valid  input  1  rx_data valid.
REQ-009 SHALL have port rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready.
REQ-010 SHALL have port we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port waddr  output  ADDR_W  word address of write.
REQ-012 SHALL have port wdata  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_hold  output  1  holds the CPU core in reset while high.
REQ-014 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CHECK, DONE.
REQ-016 IDLE: start accepted -> LOAD if 1 <= len_words <= DEPTH_WORDS; otherwise -> DONE with err=1, no writes.
REQ-017 start SHALL be ignored in LOAD and CHECK; start in DONE SHALL restart as from IDLE, clearing done and err.
REQ-018 rx_ready SHALL be 1 only in LOAD and CHECK, combinationally independent of rx_valid.
REQ-019 LOAD: bytes assembled little-endian, first byte -> wdata[7:0], fourth -> wdata[31:24].
REQ-020 we SHALL pulse in the cycle after the fourth byte's handshake, waddr = word counter (starts at 0), wdata stable that cycle.
REQ-021 Word counter SHALL increment after each write; after write of word len_words-1 -> CHECK (if CHECKSUM_EN) else DONE.
REQ-022 rx_valid gaps SHALL stall assembly without loss; no byte accepted outside LOAD/CHECK.
REQ-023 busy = 1 in LOAD and CHECK; done = 1 in DONE.
REQ-024 cpu_hold SHALL be 1 from reset and from any accepted start; SHALL drop to 0 on entry to DONE only when err=0.
REQ-025 A full load of N words SHALL complete with no extra idle cycles beyond one per word write pipeline; back-to-back bytes allowed every cycle.

Reset
REQ-026 On reset low: state IDLE, counters 0, we=0, waddr=0, wdata=0, rx_ready=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-027 Reset mid-load SHALL abandon the load immediately; memory words already written are not erased.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last word, one extra byte accepted in CHECK, compared to XOR of all payload bytes; mismatch -> DONE with err=1, match -> DONE with err=0.
REQ-029 Macro undefined: CHECK state absent, LOAD -> DONE directly, err set only by REQ-016.

Structure
REQ-030 FSM state encodings and BYTES_PER_WORD=4 SHALL live in the shared defines include.
REQ-031 Byte-to-word assembly (byte index counter, shift register, word-ready pulse) SHALL be sub-module byte_packer.

Verification
REQ-032 len_words=2, bytes 13 00 00 00 93 00 10 00 -> we@waddr0=0x00000013, we@waddr1=0x00100093, done=1, cpu_hold=0.
REQ-033 len_words=0 or DEPTH_WORDS+1 -> next cycle done=1, err=1, cpu_hold=1, we never asserted.
REQ-034 len_words=1, rx_valid toggled 1-0-1-0 per byte -> single write 0xDDCCBBAA from AA BB CC DD, no byte lost.
REQ-035 reset low after 5 of 8 bytes -> all outputs at REQ-026 values, later load starts at waddr 0.
REQ-036 With IMEM_LOADER_CHECKSUM_EN, len_words=1, bytes 01 02 04 08 then 0F -> err=0; then FF -> err=1, cpu_hold=1.
REQ-037 start pulsed during LOAD -> ignored, word count and waddr sequence unchanged.
